// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  // Default widths of the word-addressed PC and of an instruction word.
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // addi x0, x0, 0 -- what decode substitutes while no instruction is valid.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating memory-wait counter. tc_o flags that the increment happening
// this cycle brings the count to MAX_WAIT, i.e. the wait budget is used up.
module fetch_wait_timer
  import fetch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise count up and stick at MAX_WAIT.
  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q >= CNT_LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch sequencer: reads imem at the current PC over req/ready,
// holds the word for decode over valid/ready and pulses pcnext once per
// completed read. A read that stalls past MAX_WAIT cycles locks into ERR.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc_reg,
  output logic              pcnext,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_err
);

  fetch_state_e      state_q;
  logic              pcnext_q;
  logic              imem_req_q;
  logic              instr_valid_q;
  logic              fetch_err_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;

  logic timer_clr;
  logic timer_en;
  logic timer_tc;

  // The counter restarts on every REQ and advances on each stalled WAIT cycle.
  assign timer_clr = (state_q == S_REQ);
  assign timer_en  = (state_q == S_WAIT) && !imem_ready;

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (timer_tc)
  );

  // Fetch FSM with registered handshake outputs and instruction capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the captured word and PC are reset too, so nothing stale survives a reset.
      state_q       <= S_IDLE;
      pcnext_q      <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; every register updates from pre-edge values.
      pcnext_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fetch_en) begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
          end
        end
        S_REQ, S_WAIT: begin
          if (imem_ready) begin
            // Data beats the timeout when both land in the same cycle.
            instr_q       <= imem_rdata;
            instr_pc_q    <= pc_reg;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            pcnext_q      <= 1'b1;
            state_q       <= S_HOLD;
          end else if ((state_q == S_WAIT) && timer_tc) begin
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= S_ERR;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            if (fetch_en) begin
              imem_req_q <= 1'b1;
              state_q    <= S_REQ;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // pc_reg only moves after pcnext from HOLD, so it is stable during a read.
  assign imem_addr   = pc_reg;
  assign pcnext      = pcnext_q;
  assign imem_req    = imem_req_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch sequencer on the consumer side of the program counter: it reads the current word-addressed PC, fetches the instruction word from instruction memory over a request/ready handshake, and hands it to decode over a valid/ready handshake. After every completed memory read it issues the one-cycle `pcnext` pulse that advances the PC. It sits between the PC register, instruction memory and the decode stage of the single-cycle RISC-V core.

## Interface
- `ADDR_W`, 32: PC / instruction-memory address width (word address).
- `DATA_W`, 32: instruction word width.
- `MAX_WAIT`, 16: maximum WAIT cycles before a memory timeout; range 1..255.

- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  fetch enable; level-sensitive.
- `pc_reg`  in  ADDR_W  current PC value from the PC block.
- `pcnext`  out  1  one-cycle pulse; the PC increments by 1 on the following edge.
- `imem_req`  out  1  memory read request.
- `imem_addr`  out  ADDR_W  read address; equals `pc_reg` while `imem_req` is high.
- `imem_ready`  in  1  memory read data is valid this cycle.
- `imem_rdata`  in  DATA_W  read data.
- `instr_valid`  out  1  instruction available to decode.
- `instr_ready`  in  1  decode accepts the instruction.
- `instr`  out  DATA_W  held instruction word.
- `instr_pc`  out  ADDR_W  PC of the held instruction.
- `fetch_err`  out  1  sticky memory-timeout flag.

## Operation
- States: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: all handshake outputs are 0. If `fetch_en` is 1, go to REQ.
- REQ:
  - `imem_req`=1 and `imem_addr`=`pc_reg`.
  - If `imem_ready`=1, capture `imem_rdata` into `instr` and `pc_reg` into `instr_pc`, then go to HOLD.
  - Otherwise clear the wait counter and go to WAIT.
- WAIT:
  - `imem_req` stays 1 and the address stays stable.
  - If `imem_ready`=1, capture as in REQ and go to HOLD.
  - Otherwise increment the counter. When it reaches `MAX_WAIT`, go to ERR.
- HOLD:
  - `instr_valid`=1, with `instr` and `instr_pc` stable.
  - `pcnext`=1 in the first HOLD cycle only.
  - On `instr_valid`&`instr_ready`: go to REQ if `fetch_en`=1, else to IDLE.
  - Without `instr_ready`, stay in HOLD; `pcnext` is not repeated.
- ERR:
  - `fetch_err`=1, `imem_req`=0, `instr_valid`=0, `pcnext`=0.
  - ERR is left only by `reset`.
- Dropping `fetch_en` in REQ or WAIT does not abort the read. The outstanding read completes, the instruction is delivered in HOLD, and the block then goes to IDLE.
- `imem_ready` is ignored while `imem_req`=0.
- The wait counter is $clog2(`MAX_WAIT`+1) bits wide and saturates; it never wraps.

## Timing
- Reset values: state IDLE; `pcnext`, `imem_req`, `instr_valid`, `fetch_err` = 0; `instr`, `instr_pc`, wait counter = 0.
- `reset` overrides every state, including mid-request and HOLD. An outstanding read is abandoned and no `pcnext` is issued.
- `imem_addr` is combinational from `pc_reg`. `pc_reg` is stable during REQ/WAIT because `pcnext` is only issued from HOLD.
- Latency with zero-wait memory:
  - `fetch_en` rising in IDLE → REQ on the next edge.
  - REQ handshake → `instr_valid` and `pcnext` one cycle later.
  - The PC reflects +1 by the following REQ.
- Throughput: at best one instruction per 2 cycles (REQ, HOLD, REQ, …) with `instr_ready` tied high.
- Timeout: with continuous stall, ERR is entered `MAX_WAIT`+1 cycles after REQ.
- Simultaneous `imem_ready` and the timeout terminal count in WAIT: the data wins; go to HOLD with no error.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, HOLD, ERR);
  - default `ADDR_W` / `DATA_W`;
  - the NOP encoding 32'h00000013, used by the decode stage when `instr_valid`=0.
- One sub-module, `fetch_wait_timer`: the saturating counter with clear/enable inputs and a terminal-count output.
- The FSM and the capture registers live in `instr_fetch`.

## Test plan
- Reset, then `fetch_en`=1, zero-wait memory, `pc_reg` starting at 0, `instr_ready`=1 → `imem_addr` 0,1,2 on successive REQ cycles; `instr_pc` 0,1,2; exactly one `pcnext` per instruction; 2-cycle cadence.
- Memory stalls 3 cycles at `pc_reg`=5 with `imem_rdata`=32'h00500093 → `imem_req` high for 4 cycles with `imem_addr`=5; `instr`=32'h00500093 and `instr_pc`=5 in HOLD; one `pcnext`.
- `instr_ready` held low 4 cycles in HOLD → `instr` stable, `pcnext` high only in the first HOLD cycle, no new `imem_req`.
- `MAX_WAIT`=4 and `imem_ready` never asserted → `fetch_err`=1 after 5 cycles. It stays 1 with `imem_req`=0 until `reset`, after which all outputs are 0.
- `fetch_en` dropped during WAIT → the read completes, the instruction is delivered, then IDLE with no further `imem_req`.
- `reset` pulsed during WAIT → next cycle IDLE, all outputs 0, no `pcnext`.
